// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants (opcodes, op classes, field positions, NOP)
// plus the encode and legality helpers used by instr_encoder.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;

    typedef enum logic [2:0] {
        OP_ALU_R     = 3'd0,
        OP_ALU_I     = 3'd1,
        OP_BRANCH_EQ = 3'd2,
        OP_JUMP      = 3'd3,
        OP_LOAD      = 3'd4,
        OP_STORE     = 3'd5
    } op_class_e;

    function automatic logic [31:0] encode_word(
        input logic [2:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [3:0]  funct,
        input logic [31:0] imm
    );
        logic [31:0] w_rd, w_rs1, w_rs2, w_f3, w_f7, enc;
        w_rd  = 32'(rd) << RD_LSB;
        w_rs1 = 32'(rs1) << RS1_LSB;
        w_rs2 = 32'(rs2) << RS2_LSB;
        w_f3  = 32'(funct[2:0]) << F3_LSB;
        w_f7  = 32'({1'b0, funct[3], 5'b0}) << F7_LSB;
        enc   = NOP_INSTR;
        case (op)
            OP_ALU_R: enc = w_f7 | w_rs2 | w_rs1 | w_f3 | w_rd | {25'd0, OPC_OP};
            OP_ALU_I: begin
                // Shifts (funct3 001/101) carry funct7[5] above a 5-bit shamt.
                if (funct[1:0] == 2'b01)
                    enc = w_f7 | {7'd0, imm[4:0], 20'd0} | w_rs1 | w_f3 | w_rd | {25'd0, OPC_OP_IMM};
                else
                    enc = {imm[11:0], 20'd0} | w_rs1 | w_f3 | w_rd | {25'd0, OPC_OP_IMM};
            end
            OP_LOAD:  enc = {imm[11:0], 20'd0} | w_rs1 | w_f3 | w_rd | {25'd0, OPC_LOAD};
            OP_STORE: enc = {imm[11:5], 25'd0} | w_rs2 | w_rs1 | w_f3
                          | {20'd0, imm[4:0], 7'd0} | {25'd0, OPC_STORE};
            OP_BRANCH_EQ: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
            OP_JUMP:      enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default:      enc = NOP_INSTR;
        endcase
        return enc;
    endfunction

    function automatic logic fields_legal(input logic [2:0] op, input logic [31:0] imm);
        logic signed [31:0] s;
        logic ok;
        s  = $signed(imm);
        ok = 1'b0;
        case (op)
            OP_ALU_R:                   ok = 1'b1;
            OP_ALU_I, OP_LOAD, OP_STORE: ok = (s >= -32'sd2048) && (s <= 32'sd2047);
            OP_BRANCH_EQ: ok = (s >= -32'sd4096) && (s <= 32'sd4094) && !imm[0];
            OP_JUMP:      ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && !imm[0];
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of instr_encoder: field request in, addressed word out.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [3:0]        in_funct;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_count;
    logic              err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_count, err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_count, err
    );
endinterface

// File: rtl/instr_fifo.sv
// Small synchronous fall-through FIFO; when empty the read port keeps showing
// the last word popped (zero after reset).
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_last;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = o_empty ? r_last : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_last <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_last <= r_mem[r_rptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/instr_encoder.sv
// RV32I word assembler feeding an addressed output FIFO for the program loader.
// Optional INSTR_ENC_CHECK_EN adds immediate/op range checking with a sticky err.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            arst,
    instr_encoder_if.slave  bus
);
    logic              r_init;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;
    logic [31:0]       w_enc;
    logic [31:0]       w_word;
    logic [31:0]       w_head;

    // r_init keeps in_ready low while reset is asserted and until the first edge after.
    assign bus.in_ready  = r_init && !w_full;
    assign w_accept      = bus.in_valid && r_init && !w_full;
    assign w_pop         = !w_empty && bus.out_ready;
    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_head;
    assign bus.out_addr  = r_addr;
    assign bus.out_count = r_count;

    assign w_enc = encode_word(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2,
                               bus.in_funct, bus.in_imm);

`ifdef INSTR_ENC_CHECK_EN
    logic w_bad;
    logic r_err;

    assign w_bad   = !fields_legal(bus.in_op, bus.in_imm);
    assign w_word  = w_bad ? NOP_INSTR : w_enc;
    assign bus.err = r_err;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)                  r_err <= 1'b0;
        else if (w_accept && w_bad) r_err <= 1'b1;
    end
`else
    assign w_word  = w_enc;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_init  <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_pop) begin
                r_addr  <= r_addr + ADDR_W'(4);
                r_count <= r_count + 16'd1;
            end
        end
    end

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .i_push  (w_accept),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, addressing, backpressure
// and reset flush; err expectation follows INSTR_ENC_CHECK_EN.
module tb_instr_encoder;
    logic clk;
    logic arst;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_addr;
    logic [15:0] exp_count;

`ifdef INSTR_ENC_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    instr_encoder_if #(.ADDR_W(32)) bus ();

    instr_encoder #(
        .ADDR_W     (32),
        .BASE_ADDR  (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200us");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [3:0] funct, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_funct = funct;
        bus.in_imm   = imm;
    endtask

    // Called at a negedge with the FIFO empty: accept, check the word, pop it.
    task automatic enc_step(input string tag, input logic [2:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] funct,
                            input logic [31:0] imm, input logic [31:0] exp_word, input logic exp_err);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        drive(op, rd, rs1, rs2, funct, imm);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_instr"}, bus.out_instr, exp_word);
        chk({tag, "_addr"}, bus.out_addr, exp_addr);
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 16'd1;
        chk({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_hold"}, bus.out_instr, exp_word);
        chk({tag, "_count"}, 32'(bus.out_count), 32'(exp_count));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_addr  = 32'h0;
        exp_count = 16'd0;
        arst = 1'b1;
        bus.out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_addr", bus.out_addr, 32'h0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        arst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        enc_step("alu_r", 3'd0, 5'd3, 5'd1, 5'd2, 4'h0, 32'd0, 32'h002081B3, 1'b0);
        enc_step("alu_i", 3'd1, 5'd5, 5'd0, 5'd0, 4'h0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
        enc_step("load", 3'd4, 5'd6, 5'd2, 5'd0, 4'h2, 32'd8, 32'h00812303, 1'b0);
        enc_step("store", 3'd5, 5'd0, 5'd2, 5'd6, 4'h2, 32'd12, 32'h00612623, 1'b0);
        enc_step("beq", 3'd2, 5'd0, 5'd1, 5'd2, 4'h0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
        enc_step("jal", 3'd3, 5'd1, 5'd0, 5'd0, 4'h0, 32'd8, 32'h008000EF, 1'b0);
        enc_step("srai", 3'd1, 5'd1, 5'd2, 5'd0, 4'hD, 32'd3, 32'h40315093, 1'b0);
        enc_step("imm_ovf", 3'd1, 5'd0, 5'd0, 5'd0, 4'h0, 32'd4096, 32'h00000013, CHECK_ON);
        enc_step("op7", 3'd7, 5'd9, 5'd9, 5'd9, 4'h0, 32'd0, 32'h00000013, CHECK_ON);

        // Two words queued, then an asynchronous reset mid-clock flushes them.
        drive(3'd0, 5'd3, 5'd1, 5'd2, 4'h0, 32'd0);
        @(negedge clk);
        drive(3'd4, 5'd6, 5'd2, 5'd0, 4'h2, 32'd8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("q2_full", 32'(bus.in_ready), 32'd0);
        chk("q2_valid", 32'(bus.out_valid), 32'd1);
        arst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_out_instr", bus.out_instr, 32'h0);
        chk("arst_out_addr", bus.out_addr, 32'h0);
        chk("arst_out_count", 32'(bus.out_count), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        chk("arst_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Backpressure: three requests against a two-entry buffer.
        drive(3'd0, 5'd3, 5'd1, 5'd2, 4'h0, 32'd0);
        @(negedge clk);
        chk("bp_rdy_after_1", 32'(bus.in_ready), 32'd1);
        drive(3'd1, 5'd5, 5'd0, 5'd0, 4'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("bp_rdy_after_2", 32'(bus.in_ready), 32'd0);
        drive(3'd4, 5'd6, 5'd2, 5'd0, 4'h2, 32'd8);
        @(negedge clk);
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head_a", bus.out_instr, 32'h002081B3);
        chk("bp_addr_a", bus.out_addr, 32'h0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", bus.out_instr, 32'hFFF00293);
        chk("bp_addr_b", bus.out_addr, 32'h4);
        chk("bp_rdy_after_pop", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_head_c", bus.out_instr, 32'h00812303);
        chk("bp_addr_c", bus.out_addr, 32'h8);
        chk("bp_valid_c", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_drained", 32'(bus.out_valid), 32'd0);
        chk("bp_count", 32'(bus.out_count), 32'd3);
        chk("bp_next_addr", bus.out_addr, 32'hC);
        repeat (2) @(negedge clk);
        chk("bp_no_extra", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
